// File: rtl/des_sbox_pipe.sv
// des_sbox_pipe: DES S-box substitution stage with valid/ready handshakes on both sides.
// A 48-bit key-mixed word is accepted, LANES S-boxes are evaluated per cycle over
// NGRP = 8/LANES passes, and the 32-bit result is presented until taken downstream.
// Optional build macro: DES_SBOX_PPERM_EN folds the DES P permutation into the output.
module des_sbox_pipe #(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        done
);

  localparam int unsigned NGRP = 8 / LANES;
  localparam int unsigned GrpW = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gen_lanes_check
    $error("des_sbox_pipe: LANES must be 1, 2, 4 or 8");
  end

  // S-box tables, 64 nibbles each; entry (row*16 + col) sits at the 4*(63-index) offset.
  localparam logic [255:0] SboxS1 =
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] SboxS2 =
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] SboxS3 =
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] SboxS4 =
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] SboxS5 =
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] SboxS6 =
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] SboxS7 =
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] SboxS8 =
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  // box: 0 = S1 ... 7 = S8; chunk bits {5,0} pick the row, bits [4:1] the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] c);
    logic [5:0]   idx;
    logic [255:0] tbl;
    idx = {c[5], c[0], c[4:1]};
    case (box)
      3'd0:    tbl = SboxS1;
      3'd1:    tbl = SboxS2;
      3'd2:    tbl = SboxS3;
      3'd3:    tbl = SboxS4;
      3'd4:    tbl = SboxS5;
      3'd5:    tbl = SboxS6;
      3'd6:    tbl = SboxS7;
      default: tbl = SboxS8;
    endcase
    return tbl[{~idx, 2'b00} +: 4];
  endfunction

  logic [1:0]      state_q, state_d;
  logic [GrpW-1:0] grp_q, grp_d;
  logic [47:0]     din_q, din_d;
  logic [31:0]     nib_q, nib_d;
  logic [31:0]     out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;

  logic [31:0]     nib_next;
  logic [31:0]     result;
  logic [2:0]      lane_idx;

  // Evaluate the current group of LANES chunks and merge their nibbles.
  always_comb begin
    nib_next = nib_q;
    lane_idx = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_idx = 3'(32'(grp_q) * LANES + 32'(l));
      nib_next[{lane_idx, 2'b00} +: 4] =
        sbox_lookup(3'd7 - lane_idx, din_q[6'(lane_idx) * 6'd6 +: 6]);
    end
  end

`ifdef DES_SBOX_PPERM_EN
  localparam int unsigned PTbl [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                         1, 15, 23, 26,  5, 18, 31, 10,
                                         2,  8, 24, 14, 32, 27,  3,  9,
                                        19, 13, 30,  6, 22, 11,  4, 25};

  // Output bit k (1 = MSB) takes S-box concatenation bit PTbl[k-1], same numbering.
  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < 32; k++) begin
      p[31 - k] = s[32 - PTbl[k]];
    end
    return p;
  endfunction

  assign result = p_perm(nib_next);
`else
  assign result = nib_next;
`endif

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign done      = done_q;

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    din_d       = din_q;
    nib_d       = nib_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          din_d   = in_data;
          grp_d   = '0;
          nib_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        nib_d = nib_next;
        grp_d = grp_q + 1'b1;
        if (grp_q == GrpW'(NGRP - 1)) begin
          state_d     = StDone;
          out_d       = result;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            // Back-to-back accept in the same cycle the result is taken.
            din_d   = in_data;
            grp_d   = '0;
            nib_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grp_q       <= '0;
      din_q       <= '0;
      nib_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      din_q       <= din_d;
      nib_q       <= nib_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule
